// File: rtl/digit_accumulator.sv
// digit_accumulator: builds an unsigned number from a serial digit stream
// (acc <= acc*RADIX + digit) and publishes it to a separate output register
// one cycle after a commit request.
// Optional feature: define DIGACC_BKSP_EN to add the bksp_i port and
// the last-digit removal (divide-by-RADIX) path.
module digit_accumulator #(
    parameter  int WIDTH      = 16,
    parameter  int RADIX      = 10,
    parameter  int DIGIT_W    = 4,
    parameter  int MAX_DIGITS = 5,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DIGIT_W-1:0] digit_in_i,
    input  logic               digit_valid_i,
    output logic               digit_ready_o,
    input  logic               commit_i,
    input  logic               clear_i,
`ifdef DIGACC_BKSP_EN
    input  logic               bksp_i,
`endif
    output logic [WIDTH-1:0]   value_o,
    output logic               value_valid_o,
    output logic [CNT_W-1:0]   digit_count_o,
    output logic               overflow_o,
    output logic               bad_digit_o
);

    // Extra headroom so acc*RADIX+digit can be compared against 2^WIDTH-1
    localparam int EXT = WIDTH + $clog2(RADIX) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_DIGITS);
    localparam logic [DIGIT_W:0]   RADIX_D = (DIGIT_W + 1)'(RADIX);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             vv_q, vv_d;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;
    logic             pend_q, pend_d;

    logic             bksp_req;
    logic             digit_fire;
    logic             digit_ok;
    logic             fresh;
    logic [WIDTH-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic [EXT-1:0]   prod;
    logic             fits;

`ifdef DIGACC_BKSP_EN
    assign bksp_req = bksp_i;
`else
    assign bksp_req = 1'b0;
`endif

    assign digit_ready_o = (cnt_q < MAX_C) & ~clear_i & ~commit_i & ~bksp_req;
    assign digit_fire    = digit_valid_i & digit_ready_o;
    assign digit_ok      = {1'b0, digit_in_i} < RADIX_D;

    // A digit arriving while a publish is pending, or while holding a
    // committed value, starts a brand-new number rather than extending acc.
    assign fresh    = pend_q | (state_q == HOLD);
    assign base_acc = fresh ? '0 : acc_q;
    assign base_cnt = pend_q ? '0 : cnt_q;
    assign prod     = EXT'(base_acc) * EXT'(RADIX) + EXT'(digit_in_i);
    assign fits     = (prod[EXT-1:WIDTH] == '0);

    // Next-state: clear beats everything; a pending publish lands first and
    // the request decoded this cycle (commit > bksp > digit) layers on top.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        vv_d    = vv_q;
        ovf_d   = ovf_q;
        bad_d   = 1'b0;
        pend_d  = 1'b0;
        if (clear_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            vv_d    = 1'b0;
            state_d = IDLE;
        end else begin
            if (pend_q) begin
                value_d = acc_q;
                vv_d    = 1'b1;
                ovf_d   = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = HOLD;
            end
            if (commit_i) begin
                pend_d = 1'b1;
            end
`ifdef DIGACC_BKSP_EN
            else if (bksp_req) begin
                if (state_q == ACCUM && !pend_q) begin
                    acc_d = acc_q / WIDTH'(RADIX);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = IDLE;
                end
            end
`endif
            else if (digit_fire) begin
                if (!digit_ok) begin
                    bad_d = 1'b1;
                end else if (!fits) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d   = prod[WIDTH-1:0];
                    cnt_d   = base_cnt + CNT_W'(1);
                    state_d = ACCUM;
                    if (!pend_q) vv_d = 1'b0;
                end
            end
        end
    end

    // State registers, async active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
            pend_q  <= pend_d;
        end
    end

    assign value_o       = value_q;
    assign value_valid_o = vv_q;
    assign digit_count_o = cnt_q;
    assign overflow_o    = ovf_q;
    assign bad_digit_o   = bad_q;

endmodule

// File: tb/tb_digit_accumulator.sv
// Directed bench for digit_accumulator (WIDTH=16, RADIX=10, MAX_DIGITS=5).
// Backspace sequence is included when DIGACC_BKSP_EN is defined.
module tb_digit_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit_in = '0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
    logic        bksp = 1'b0;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  digit_count;
    logic        overflow;
    logic        bad_digit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_accumulator dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .digit_in_i   (digit_in),
        .digit_valid_i(digit_valid),
        .digit_ready_o(digit_ready),
        .commit_i     (commit),
        .clear_i      (clear),
`ifdef DIGACC_BKSP_EN
        .bksp_i       (bksp),
`endif
        .value_o      (value),
        .value_valid_o(value_valid),
        .digit_count_o(digit_count),
        .overflow_o   (overflow),
        .bad_digit_o  (bad_digit)
    );

    typedef struct {
        logic       dv;
        logic [3:0] d;
        logic       cm;
        logic       cl;
        logic       rdy;
        int         cnt;
        logic       vv;
        int         val;
        logic       ovf;
        logic       bad;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic cm,
                         input logic cl, input logic bk);
        digit_valid = dv;
        digit_in    = d;
        commit      = cm;
        clear       = cl;
        bksp        = bk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int cnt, input logic vv, input int val,
                           input logic ovf, input logic bad);
        chk({nm, ".count"}, 32'(digit_count), cnt);
        chk({nm, ".vvalid"}, 32'(value_valid), 32'(vv));
        chk({nm, ".value"}, 32'(value), val);
        chk({nm, ".ovf"}, 32'(overflow), 32'(ovf));
        chk({nm, ".bad"}, 32'(bad_digit), 32'(bad));
    endtask

    initial begin
        // main table: basic number, overflow, bad digit, clear, commit cancel
        tbl[0]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 0, 1, 2, 0, 0, 0, 0};
        tbl[2]  = '{1, 3, 0, 0, 1, 3, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 3, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 1, 123, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 1, 123, 0, 0};
        tbl[6]  = '{1, 6, 0, 0, 1, 1, 0, 123, 0, 0};
        tbl[7]  = '{1, 5, 0, 0, 1, 2, 0, 123, 0, 0};
        tbl[8]  = '{1, 5, 0, 0, 1, 3, 0, 123, 0, 0};
        tbl[9]  = '{1, 3, 0, 0, 1, 4, 0, 123, 0, 0};
        tbl[10] = '{1, 6, 0, 0, 1, 4, 0, 123, 1, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 4, 0, 123, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 1, 6553, 0, 0};
        tbl[13] = '{1, 11, 0, 0, 1, 0, 1, 6553, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 1, 6553, 0, 0};
        tbl[15] = '{1, 4, 0, 0, 1, 1, 0, 6553, 0, 0};
        tbl[16] = '{1, 11, 0, 0, 1, 1, 0, 6553, 0, 1};
        tbl[17] = '{1, 2, 0, 0, 1, 2, 0, 6553, 0, 0};
        tbl[18] = '{0, 0, 1, 0, 0, 2, 0, 6553, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 1, 0, 1, 42, 0, 0};
        tbl[20] = '{1, 7, 0, 0, 1, 1, 0, 42, 0, 0};
        tbl[21] = '{0, 0, 1, 0, 0, 1, 0, 42, 0, 0};
        tbl[22] = '{0, 0, 0, 1, 0, 0, 0, 42, 0, 0};
        tbl[23] = '{0, 0, 0, 0, 1, 0, 0, 42, 0, 0};
        tbl[24] = '{1, 3, 0, 0, 1, 1, 0, 42, 0, 0};
        tbl[25] = '{1, 9, 0, 1, 0, 0, 0, 42, 0, 0};
        tbl[26] = '{0, 0, 1, 0, 0, 0, 0, 42, 0, 0};
        tbl[27] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

        // reset state
        drive(0, 0, 0, 0, 0);
        #12;
        chk_out("reset", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].dv, tbl[i].d, tbl[i].cm, tbl[i].cl, 1'b0);
            #1;
            chk($sformatf("row%0d.ready", i), 32'(digit_ready), 32'(tbl[i].rdy));
            tick();
            chk_out($sformatf("row%0d", i), tbl[i].cnt, tbl[i].vv, tbl[i].val,
                    tbl[i].ovf, tbl[i].bad);
        end
        drive(0, 0, 0, 0, 0);

        // digit limit: 6th digit stalls until the number is committed
        for (int k = 1; k <= 5; k++) begin
            drive(1, 4'(k), 0, 0, 0);
            #1;
            chk($sformatf("lim%0d.ready", k), 32'(digit_ready), 1);
            tick();
        end
        chk("lim.count5", 32'(digit_count), 5);
        drive(1, 6, 0, 0, 0);
        #1;
        chk("lim.stall_ready", 32'(digit_ready), 0);
        tick();
        tick();
        chk("lim.stall_count", 32'(digit_count), 5);
        drive(1, 6, 1, 0, 0);
        tick();
        drive(1, 6, 0, 0, 0);
        #1;
        chk("lim.pend_ready", 32'(digit_ready), 0);
        tick();
        chk_out("lim.publish", 0, 1, 12345, 0, 0);
        #1;
        chk("lim.resume_ready", 32'(digit_ready), 1);
        tick();
        chk_out("lim.sixth", 1, 0, 12345, 0, 0);
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk_out("lim.second", 0, 1, 6, 0, 0);

`ifdef DIGACC_BKSP_EN
        // backspace: ignored in IDLE, removes last digit in ACCUM
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        chk_out("bk.idle", 0, 0, 6, 0, 0);
        drive(1, 4, 0, 0, 0);
        tick();
        drive(1, 7, 0, 0, 0);
        tick();
        chk("bk.cnt2", 32'(digit_count), 2);
        drive(1, 5, 0, 0, 1);
        #1;
        chk("bk.ready", 32'(digit_ready), 0);
        tick();
        chk("bk.cnt1", 32'(digit_count), 1);
        drive(1, 9, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk_out("bk.result", 0, 1, 49, 0, 0);
`endif

        // async reset while a publish is pending: nothing gets published
        drive(1, 9, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("rst_after", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
